subbytes_scheduler: RTL
=======================

Name: subbytes_scheduler

Overview:
- Time-shares a reduced bank of S-box lanes between two requesters.
- Requester 1 is the cipher round datapath, which sends a 128-bit state for SubBytes.
- Requester 2 is key expansion, which sends a 32-bit word for SubWord.
- Replaces the 16-instance combinational SubBytes with LANES S-box instances, sequenced over multiple beats, and arbitrates between the two request streams with valid/ready handshakes.

Parameters:
- LANES, default 4: number of S-box instances; legal values 4, 8, 16; BEATS = 16/LANES.

Ports:
- clk  in  1  clock; all registers on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_in_valid  in  1  state request valid.
- st_in_ready  out  1  state request accepted when valid&ready.
- st_in  in  128  input state; byte 0 = [127:120].
- st_out_valid  out  1  one-cycle pulse; st_out is valid.
- st_out  out  128  SubBytes result; held until the next state completion.
- kw_in_valid  in  1  key-word request valid.
- kw_in_ready  out  1  key-word request accepted when valid&ready.
- kw_in  in  32  input word; byte 0 = [31:24].
- kw_out_valid  out  1  one-cycle pulse; kw_out is valid.
- kw_out  out  32  SubWord result; held until the next key completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, beat counter=0, last_grant=STATE, preempt_used=0, st_out=0, kw_out=0, both valid pulses=0, busy=0. Any in-flight job is discarded with no output pulse. All ready outputs read 0 while rst_n=0.
- Request data is captured into internal registers at acceptance, so requesters need not hold it afterwards.
- FSM states: IDLE, ST_RUN, KW_RUN, KW_INS (KW_INS exists only with the optional feature).
- IDLE, state only valid: st_in_ready=1; on accept go to ST_RUN with beat=0.
- IDLE, key only valid: kw_in_ready=1; on accept go to KW_RUN.
- IDLE, both valid: grant the requester opposite to last_grant; only the granted ready is high. After reset, a tie therefore goes to KEY. last_grant updates on every accept.
- ST_RUN, beat k (0..BEATS-1): lanes substitute state bits [127-8*LANES*k -: 8*LANES] and write the result into the matching st_out slice register.
- st_out slices update beat by beat. Consumers sample st_out only on st_out_valid.
- ST_RUN, after beat BEATS-1: st_out_valid pulses in the next cycle and the FSM returns to IDLE.
- State latency: accept in cycle 0, st_out_valid in cycle BEATS+1 (cycle 5 for LANES=4).
- KW_RUN (one cycle): lanes 0..3 substitute the captured word. kw_out_valid pulses in the next cycle and the FSM returns to IDLE. Key latency: accept in cycle 0, valid in cycle 2.
- Both ready outputs are 0 in ST_RUN and KW_RUN, except as allowed by the optional feature.
- Ready is asserted only in IDLE, so the earliest re-accept is the cycle after the output pulse. Sustained throughput: one state per BEATS+2 cycles, one key word per 3 cycles.
- Output pulses are never backpressured; a missed pulse is lost.
- Lane byte mapping is fixed: lane i processes byte i of the current beat slice.

Optional Feature:
KEY_PREEMPT_EN
- Defined: in ST_RUN, while beat is 1..BEATS-1 and preempt_used=0, kw_in_ready=1. A key word accepted there is captured.
  - The current beat still completes in that cycle.
  - The next cycle is KW_INS: lanes serve the key word and the beat counter holds.
  - ST_RUN then resumes; kw_out_valid pulses in the first resumed cycle.
  - preempt_used is set and cleared on state completion, so at most one preemption occurs per state job. State latency becomes BEATS+2.
  - LANES=16 gives no preempt window.
- Undefined: kw_in_ready=0 outside IDLE, KW_INS is absent, and latencies are exactly as in Behaviour.

Test Plan:
1. Reset, then state of all 0x00, no key traffic -> st_out_valid in cycle 5 after accept; st_out = 128'h6363...63; busy high in cycles 1-4.
2. kw_in=0xCF4F3C09 alone -> kw_out_valid in cycle 2; kw_out=0x8A84EB01.
3. Both valid in the same cycle after reset (state=0x00..0F in byte order, key=0x0053FF01) -> key granted first, kw_out=0x63ED167C. State accepted in the next IDLE cycle; st_out=0x637C777BF26B6FC53001672BFED7AB76.
4. Both held valid continuously -> grants alternate KEY, STATE, KEY, STATE; no request starves; valid pulses match the accept order.
5. Assert rst_n=0 in cycle 3 of a state job -> no st_out_valid; outputs return to 0; a new request after release completes normally.
6. With KEY_PREEMPT_EN, key valid during beat 2 -> key accepted. kw_out_valid arrives before st_out_valid; state latency is 6; a second key request waits for IDLE.

Source files
------------

// File: rtl/subbytes_scheduler.sv
// Time-shares LANES AES S-boxes between a 128-bit state requester and a 32-bit key-word requester.
// Optional build macro KEY_PREEMPT_EN lets one key word cut into a running state job.
module subbytes_scheduler #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    output logic [127:0] st_out,
    input  logic         kw_in_valid,
    output logic         kw_in_ready,
    input  logic [31:0]  kw_in,
    output logic         kw_out_valid,
    output logic [31:0]  kw_out,
    output logic         busy
);

    localparam int BEATS = 16 / LANES;
    localparam int SW    = 8 * LANES;
    localparam logic GRANT_ST  = 1'b0;
    localparam logic GRANT_KEY = 1'b1;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

`ifdef KEY_PREEMPT_EN
    typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN, KW_INS} stateT;
`else
    typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} stateT;
`endif

    stateT          state, nextState;
    logic [1:0]     beat;
    logic           lastGrant;
    logic [127:0]   stReg;
    logic [31:0]    kwReg;
    logic [SW-1:0]  laneIn, laneOut;
    logic           stReady, kwReady, stAccept, kwAccept;
    logic           lastBeat, keyPhase;
`ifdef KEY_PREEMPT_EN
    logic           preemptUsed;
    logic           pendingDone;
`endif

    assign lastBeat    = (beat == 2'(BEATS - 1));
    assign stAccept    = stReady & st_in_valid;
    assign kwAccept    = kwReady & kw_in_valid;
    assign st_in_ready = stReady;
    assign kw_in_ready = kwReady;
    assign busy        = (state != IDLE);
`ifdef KEY_PREEMPT_EN
    assign keyPhase    = (state == KW_RUN) || (state == KW_INS);
`else
    assign keyPhase    = (state == KW_RUN);
`endif

    // Key words always ride lanes 0..3; higher lanes idle on zero.
    always_comb begin
        laneIn = '0;
        if (state == ST_RUN) begin
            laneIn = stReg[127 - SW * int'(beat) -: SW];
        end else if (keyPhase) begin
            laneIn[SW-1 -: 32] = kwReg;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : gLane
        assign laneOut[SW-1-8*i -: 8] = sbox(laneIn[SW-1-8*i -: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Ready stays low while an output pulse is out, so re-accept lands the cycle after it.
    always_comb begin
        nextState = state;
        stReady   = 1'b0;
        kwReady   = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && !st_out_valid && !kw_out_valid) begin
                    if (st_in_valid && kw_in_valid) begin
                        stReady = (lastGrant == GRANT_KEY);
                        kwReady = (lastGrant != GRANT_KEY);
                    end else begin
                        stReady = st_in_valid;
                        kwReady = kw_in_valid;
                    end
                end
                if (stReady && st_in_valid)      nextState = ST_RUN;
                else if (kwReady && kw_in_valid) nextState = KW_RUN;
            end
            ST_RUN: begin
                if (lastBeat) nextState = IDLE;
`ifdef KEY_PREEMPT_EN
                kwReady = rst_n && (beat != 2'd0) && !preemptUsed;
                if (kwReady && kw_in_valid) nextState = KW_INS;
`endif
            end
            KW_RUN: nextState = IDLE;
`ifdef KEY_PREEMPT_EN
            KW_INS: nextState = pendingDone ? IDLE : ST_RUN;
`endif
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat         <= 2'd0;
            lastGrant    <= GRANT_ST;
            stReg        <= '0;
            kwReg        <= '0;
            st_out       <= '0;
            kw_out       <= '0;
            st_out_valid <= 1'b0;
            kw_out_valid <= 1'b0;
`ifdef KEY_PREEMPT_EN
            preemptUsed  <= 1'b0;
            pendingDone  <= 1'b0;
`endif
        end else begin
            st_out_valid <= 1'b0;
            kw_out_valid <= 1'b0;
            if (stAccept) begin
                stReg     <= st_in;
                beat      <= 2'd0;
                lastGrant <= GRANT_ST;
            end
            if (kwAccept) begin
                kwReg     <= kw_in;
                lastGrant <= GRANT_KEY;
            end
            case (state)
                ST_RUN: begin
                    st_out[127 - SW * int'(beat) -: SW] <= laneOut;
                    beat <= lastBeat ? 2'd0 : beat + 2'd1;
                    if (nextState == IDLE) begin
                        st_out_valid <= 1'b1;
`ifdef KEY_PREEMPT_EN
                        preemptUsed  <= 1'b0;
`endif
                    end
`ifdef KEY_PREEMPT_EN
                    // A preempt on the final beat finishes the state right after the key slot.
                    if (kwAccept) begin
                        preemptUsed <= 1'b1;
                        pendingDone <= lastBeat;
                    end
`endif
                end
                KW_RUN: begin
                    kw_out       <= laneOut[SW-1 -: 32];
                    kw_out_valid <= 1'b1;
                end
`ifdef KEY_PREEMPT_EN
                KW_INS: begin
                    kw_out       <= laneOut[SW-1 -: 32];
                    kw_out_valid <= 1'b1;
                    if (pendingDone) begin
                        st_out_valid <= 1'b1;
                        preemptUsed  <= 1'b0;
                        pendingDone  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
